// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port data memory between the core MEM
// stage and an auxiliary master (host loader / display reader).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   core_req/we/addr/wdata core request, held until core_gnt
//   core_gnt              core owns the memory this cycle (combinational)
//   core_rvalid/rdata     registered read response, one cycle after grant
//   aux_req/we/addr/wdata aux request, held until aux_gnt
//   aux_gnt               aux owns the memory this cycle (combinational)
//   aux_rvalid/rdata      registered read response, one cycle after grant
//   mem_we/addr/wdata     drive to mem_stage write_enable/address/write_data
//   mem_rdata             combinational read_data from mem_stage
//
// Build option
//   MEM_ARB_ROUND_ROBIN_EN  defined: alternate on contention using last_gnt
//                           (no aging counter, MAX_WAIT unused).
//                           undefined: core priority with MAX_WAIT aging.

module mem_arbiter #(
    parameter int N        = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         core_req,
    input  logic         core_we,
    input  logic [N-1:0] core_addr,
    input  logic [N-1:0] core_wdata,
    output logic         core_gnt,
    output logic         core_rvalid,
    output logic [N-1:0] core_rdata,

    input  logic         aux_req,
    input  logic         aux_we,
    input  logic [N-1:0] aux_addr,
    input  logic [N-1:0] aux_wdata,
    output logic         aux_gnt,
    output logic         aux_rvalid,
    output logic [N-1:0] aux_rdata,

    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_CORE = 2'd1,
        RESP_AUX  = 2'd2
    } resp_t;

    resp_t resp_sel;
    logic  aux_wins;
    logic  core_rd;
    logic  aux_rd;

    // ------------------------------------------------------------------
    // Arbitration policy
    // ------------------------------------------------------------------
`ifdef MEM_ARB_ROUND_ROBIN_EN

    typedef enum logic {
        GNT_CORE = 1'b0,
        GNT_AUX  = 1'b1
    } owner_t;

    owner_t last_gnt;

    // On contention the port that did not win last time gets the memory.
    assign aux_wins = ~core_req | (last_gnt == GNT_CORE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= GNT_CORE;
        end else if (core_gnt) begin
            last_gnt <= GNT_CORE;
        end else if (aux_gnt) begin
            last_gnt <= GNT_AUX;
        end
    end

`else

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    // Aux normally yields to the core, but once it has been denied
    // MAX_WAIT cycles in a row it takes the memory regardless.
    assign aux_wins = ~core_req | (wait_cnt >= WAIT_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (aux_gnt || !aux_req) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt < WAIT_LIM) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

`endif

    // Grants are forced low during reset so nothing reaches the memory.
    assign aux_gnt  = rst_n & aux_req & aux_wins;
    assign core_gnt = rst_n & core_req & ~aux_gnt;

    assign core_rd  = core_gnt & ~core_we;
    assign aux_rd   = aux_gnt & ~aux_we;

    // ------------------------------------------------------------------
    // Memory drive: winner's command, all zero when idle
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            core_gnt: begin
                mem_we    = core_we;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
            end
            aux_gnt: begin
                mem_we    = aux_we;
                mem_addr  = aux_addr;
                mem_wdata = aux_wdata;
            end
            default: begin
                mem_we    = 1'b0;
                mem_addr  = '0;
                mem_wdata = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read response FSM
    // resp_sel names the port whose data was captured at the last edge;
    // the rvalid flags are registered alongside it so they pulse for
    // exactly one cycle and back-to-back reads give adjacent pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_sel    <= RESP_NONE;
            core_rvalid <= 1'b0;
            aux_rvalid  <= 1'b0;
            core_rdata  <= '0;
            aux_rdata   <= '0;
        end else begin
            unique case (1'b1)
                core_rd: begin
                    resp_sel    <= RESP_CORE;
                    core_rvalid <= 1'b1;
                    aux_rvalid  <= 1'b0;
                    core_rdata  <= mem_rdata;
                end
                aux_rd: begin
                    resp_sel    <= RESP_AUX;
                    core_rvalid <= 1'b0;
                    aux_rvalid  <= 1'b1;
                    aux_rdata   <= mem_rdata;
                end
                default: begin
                    resp_sel    <= RESP_NONE;
                    core_rvalid <= 1'b0;
                    aux_rvalid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
